uart_tx: RTL

//  UART transmitter; the transmit counterpart of the team's oversampling UART receiver.

---
 rtl/uart_tx.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, stop period of SB_TICK ticks,
// paced by a shared 16x baud tick, with a one-deep holding register for back-to-back frames.
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done_tick,
  output logic       tx
);

  localparam int SW = $clog2((SB_TICK > 16) ? SB_TICK : 16);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  state_t          r_state, w_state_nxt;
  logic [SW-1:0]   r_s, w_s_nxt;
  logic [NW-1:0]   r_n, w_n_nxt;
  logic [DBIT-1:0] r_b, w_b_nxt;
  logic [DBIT-1:0] r_hold;
  logic            r_hold_vld;
  logic            r_tx, w_tx_nxt;
  logic            w_accept;
  logic            w_load;
  logic            w_done;

  // A request is taken only into an empty holding register, even on a drain cycle.
  assign w_accept = tx_start & ~r_hold_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold_vld <= 1'b0;
      r_hold     <= '0;
    end else if (w_accept) begin
      r_hold_vld <= 1'b1;
      r_hold     <= din[DBIT-1:0];
    end else if (w_load) begin
      r_hold_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_b     <= w_b_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_b_nxt     = r_b;
    w_load      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_hold_vld) begin
          w_load      = 1'b1;
          w_b_nxt     = r_hold;
          w_s_nxt     = '0;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (r_s == S_BIT_LAST) begin
            w_s_nxt     = '0;
            w_n_nxt     = '0;
            w_state_nxt = ST_DATA;
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (r_s == S_BIT_LAST) begin
            w_s_nxt = '0;
            w_b_nxt = r_b >> 1;
            if (r_n == N_LAST) w_state_nxt = ST_STOP;
            else               w_n_nxt     = r_n + 1'b1;
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (r_s == S_STOP_LAST) begin
            w_done = 1'b1;
            // Chain straight into the next start bit when a byte is already waiting.
            if (r_hold_vld) begin
              w_load      = 1'b1;
              w_b_nxt     = r_hold;
              w_s_nxt     = '0;
              w_state_nxt = ST_START;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Line level follows the next state so it changes on the same edge as the state.
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      ST_START: w_tx_nxt = 1'b0;
      ST_DATA:  w_tx_nxt = w_b_nxt[0];
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  assign tx           = r_tx;
  assign tx_ready     = ~r_hold_vld;
  assign tx_busy      = (r_state != ST_IDLE);
  assign tx_done_tick = w_done;

endmodule
